// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C transaction controller between two clients
//
// Latches the winning client's address, direction and write byte, strobes Go
// to the controller for one cycle, then waits for Done under a watchdog and
// returns status and read data to the winner.
//
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   req_i[1:0]                          request per client (bit i = client i)
//   addr0_i/addr1_i, rw0_i/rw1_i,
//   wdata0_i/wdata1_i                   per-client address, direction (1=read), write byte
//   grant_o[1:0]                        one-hot bus owner, 0 when idle
//   rsp_done_o[1:0]                     one-cycle completion pulse on the owner's bit
//   rsp_ok_o, rsp_timeout_o, rsp_data_o response fields, valid with rsp_done_o
//   go_o                                one-cycle start strobe to the controller
//   ctl_addr_o, ctl_rw_o, ctl_wdata_o   latched transaction for the controller
//   ctl_done_i, ctl_ack_ok_i,
//   ctl_rd_data_i                       completion pulse, ACK status and read byte from the controller
module i2c_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [6:0] addr0_i,
  input  logic [6:0] addr1_i,
  input  logic       rw0_i,
  input  logic       rw1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  output logic [1:0] grant_o,
  output logic [1:0] rsp_done_o,
  output logic       rsp_ok_o,
  output logic       rsp_timeout_o,
  output logic [7:0] rsp_data_o,
  output logic       go_o,
  output logic [6:0] ctl_addr_o,
  output logic       ctl_rw_o,
  output logic [7:0] ctl_wdata_o,
  input  logic       ctl_done_i,
  input  logic       ctl_ack_ok_i,
  input  logic [7:0] ctl_rd_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LAUNCH,
    S_WAIT,
    S_COMPLETE
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_gnt_q, last_gnt_d;  // index of the last served client
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rsp_done_q, rsp_done_d;
  logic          rsp_ok_q, rsp_ok_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          go_q, go_d;
  logic [6:0]    ctl_addr_q, ctl_addr_d;
  logic          ctl_rw_q, ctl_rw_d;
  logic [7:0]    ctl_wdata_q, ctl_wdata_d;

  // Winner index: a lone requester wins; on a tie the client not served last wins.
  logic win_idx;
  always_comb begin
    win_idx = 1'b0;
    case (req_i)
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_gnt_q;
      default: win_idx = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_gnt_d    = last_gnt_q;
    grant_d       = grant_q;
    rsp_done_d    = 2'b00;
    rsp_ok_d      = rsp_ok_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;
    go_d          = 1'b0;
    ctl_addr_d    = ctl_addr_q;
    ctl_rw_d      = ctl_rw_q;
    ctl_wdata_d   = ctl_wdata_q;

    case (state_q)
      S_IDLE: begin
        grant_d = 2'b00;
        if (req_i != 2'b00) begin
          state_d     = S_LATCH;
          grant_d     = win_idx ? 2'b10 : 2'b01;
          ctl_addr_d  = win_idx ? addr1_i  : addr0_i;
          ctl_rw_d    = win_idx ? rw1_i    : rw0_i;
          ctl_wdata_d = win_idx ? wdata1_i : wdata0_i;
        end
      end
      S_LATCH: begin
        state_d = S_LAUNCH;
        go_d    = 1'b1;  // registered, so Go is high during LAUNCH
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // Done is checked first so it wins over a simultaneous timeout.
        if (ctl_done_i) begin
          state_d       = S_COMPLETE;
          rsp_done_d    = grant_q;
          rsp_ok_d      = ctl_ack_ok_i;
          rsp_timeout_d = 1'b0;
          rsp_data_d    = ctl_rd_data_i;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = S_COMPLETE;
          rsp_done_d    = grant_q;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_data_d    = 8'h00;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COMPLETE: begin
        state_d       = S_IDLE;
        last_gnt_d    = grant_q[1];
        grant_d       = 2'b00;
        rsp_ok_d      = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      last_gnt_q    <= 1'b1;
      grant_q       <= 2'b00;
      rsp_done_q    <= 2'b00;
      rsp_ok_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= 8'h00;
      go_q          <= 1'b0;
      ctl_addr_q    <= 7'h00;
      ctl_rw_q      <= 1'b0;
      ctl_wdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_gnt_q    <= last_gnt_d;
      grant_q       <= grant_d;
      rsp_done_q    <= rsp_done_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      go_q          <= go_d;
      ctl_addr_q    <= ctl_addr_d;
      ctl_rw_q      <= ctl_rw_d;
      ctl_wdata_q   <= ctl_wdata_d;
    end
  end

  assign grant_o       = grant_q;
  assign rsp_done_o    = rsp_done_q;
  assign rsp_ok_o      = rsp_ok_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign rsp_data_o    = rsp_data_q;
  assign go_o          = go_q;
  assign ctl_addr_o    = ctl_addr_q;
  assign ctl_rw_o      = ctl_rw_q;
  assign ctl_wdata_o   = ctl_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [6:0] addr0 = 7'h00, addr1 = 7'h00;
  logic       rw0 = 1'b0, rw1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic [1:0] grant, rsp_done;
  logic       rsp_ok, rsp_timeout, go, ctl_rw;
  logic [7:0] rsp_data, ctl_wdata;
  logic [6:0] ctl_addr;
  logic       ctl_done = 1'b0, ctl_ack_ok = 1'b0;
  logic [7:0] ctl_rd_data = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] gnt;
    logic       ok;
    logic       to;
    logic [7:0] data;
    int         lat;
  } exp_t;
  exp_t sb[$];

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TW(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .addr0_i(addr0), .addr1_i(addr1), .rw0_i(rw0), .rw1_i(rw1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .grant_o(grant), .rsp_done_o(rsp_done), .rsp_ok_o(rsp_ok),
    .rsp_timeout_o(rsp_timeout), .rsp_data_o(rsp_data), .go_o(go),
    .ctl_addr_o(ctl_addr), .ctl_rw_o(ctl_rw), .ctl_wdata_o(ctl_wdata),
    .ctl_done_i(ctl_done), .ctl_ack_ok_i(ctl_ack_ok), .ctl_rd_data_i(ctl_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_go"}, 32'(go), 0);
    check({tag, "_rsp_done"}, 32'(rsp_done), 0);
    check({tag, "_rsp_ok"}, 32'(rsp_ok), 0);
    check({tag, "_rsp_to"}, 32'(rsp_timeout), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check({tag, "_ctl_addr"}, 32'(ctl_addr), 0);
    check({tag, "_ctl_rw"}, 32'(ctl_rw), 0);
    check({tag, "_ctl_wdata"}, 32'(ctl_wdata), 0);
  endtask

  // One full transaction. Called at a negedge with the DUT in IDLE.
  // done_at: WAIT-cycle index at which CtlDone is driven (-1 = never).
  task automatic txn(input string tag, input logic [1:0] req_v, input logic [1:0] exp_gnt,
                     input logic [6:0] exp_addr, input logic exp_rw, input logic [7:0] exp_wd,
                     input int done_at, input logic ack, input logic [7:0] rd,
                     input logic drop_in_wait);
    exp_t e;
    int   lat;
    e.gnt  = exp_gnt;
    e.ok   = (done_at >= 0) ? ack : 1'b0;
    e.to   = (done_at < 0);
    e.data = (done_at >= 0) ? rd : 8'h00;
    e.lat  = (done_at >= 0) ? done_at + 1 : TO;
    sb.push_back(e);

    req = req_v;
    @(negedge clk);
    check({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
    check({tag, "_ctl_addr"}, 32'(ctl_addr), 32'(exp_addr));
    check({tag, "_ctl_rw"}, 32'(ctl_rw), 32'(exp_rw));
    check({tag, "_ctl_wdata"}, 32'(ctl_wdata), 32'(exp_wd));
    check({tag, "_go_pre"}, 32'(go), 0);
    @(negedge clk);
    check({tag, "_go"}, 32'(go), 1);
    @(negedge clk);
    check({tag, "_go_post"}, 32'(go), 0);
    if (drop_in_wait) begin
      req   = 2'b00;
      addr0 = 7'h7F;
    end

    lat = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      if (k == done_at) begin
        ctl_done    = 1'b1;
        ctl_ack_ok  = ack;
        ctl_rd_data = rd;
      end
      @(negedge clk);
      ctl_done = 1'b0;
      if (rsp_done !== 2'b00) begin
        lat = k + 1;
        break;
      end
    end

    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_rsp_done"}, 32'(rsp_done), 32'(e.gnt));
    check({tag, "_rsp_ok"}, 32'(rsp_ok), 32'(e.ok));
    check({tag, "_rsp_to"}, 32'(rsp_timeout), 32'(e.to));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(e.data));
    check({tag, "_ctl_addr_hold"}, 32'(ctl_addr), 32'(exp_addr));
    @(negedge clk);
    check({tag, "_rsp_done_clr"}, 32'(rsp_done), 0);
    check({tag, "_grant_clr"}, 32'(grant), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Single write from client 0
    addr0 = 7'h48; rw0 = 1'b0; wdata0 = 8'hA5;
    txn("t1_wr", 2'b01, 2'b01, 7'h48, 1'b0, 8'hA5, 4, 1'b1, 8'hEE, 1'b0);
    req = 2'b00;

    // Read from client 1 with NACK
    addr1 = 7'h50; rw1 = 1'b1; wdata1 = 8'h00;
    txn("t3_rd", 2'b10, 2'b10, 7'h50, 1'b1, 8'h00, 3, 1'b0, 8'h3C, 1'b0);
    req = 2'b00;

    // Continuous tie: grants alternate starting with client 0
    addr0 = 7'h20; rw0 = 1'b0; wdata0 = 8'h11;
    addr1 = 7'h21; rw1 = 1'b1; wdata1 = 8'h22;
    txn("t2_a", 2'b11, 2'b01, 7'h20, 1'b0, 8'h11, 3, 1'b1, 8'h01, 1'b0);
    txn("t2_b", 2'b11, 2'b10, 7'h21, 1'b1, 8'h22, 3, 1'b1, 8'h02, 1'b0);
    txn("t2_c", 2'b11, 2'b01, 7'h20, 1'b0, 8'h11, 3, 1'b0, 8'h03, 1'b0);
    txn("t2_d", 2'b11, 2'b10, 7'h21, 1'b1, 8'h22, 3, 1'b1, 8'h04, 1'b0);
    req = 2'b00;

    // Watchdog timeout, then Done on the final cycle beats the timeout
    addr0 = 7'h33; rw0 = 1'b0; wdata0 = 8'h99;
    txn("t4_to", 2'b01, 2'b01, 7'h33, 1'b0, 8'h99, -1, 1'b1, 8'hFF, 1'b0);
    req = 2'b00;
    txn("t4_tie", 2'b01, 2'b01, 7'h33, 1'b0, 8'h99, TO - 1, 1'b1, 8'h6B, 1'b0);
    req = 2'b00;

    // Client 0 changes address and drops Req during WAIT
    addr0 = 7'h2A; rw0 = 1'b0; wdata0 = 8'h77;
    txn("t5_drop", 2'b01, 2'b01, 7'h2A, 1'b0, 8'h77, 6, 1'b1, 8'h00, 1'b1);

    // Reset in the middle of WAIT
    addr0 = 7'h30; wdata0 = 8'h5A; rw0 = 1'b1;
    req = 2'b01;
    repeat (4) @(negedge clk);
    req = 2'b00;
    check("t6_in_wait_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async_rst");
    @(negedge clk);
    rst = 1'b0;
    ctl_done = 1'b1; ctl_ack_ok = 1'b1; ctl_rd_data = 8'hC3;
    @(negedge clk);
    ctl_done = 1'b0;
    check("t6_stray_done", 32'(rsp_done), 0);
    check("t6_stray_grant", 32'(grant), 0);
    addr0 = 7'h41; rw0 = 1'b0; wdata0 = 8'h10;
    addr1 = 7'h42; rw1 = 1'b0; wdata1 = 8'h20;
    txn("t6_tie", 2'b11, 2'b01, 7'h41, 1'b0, 8'h10, 2, 1'b1, 8'h55, 1'b0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("end_idle_grant", 32'(grant), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C transaction controller between two requesters, e.g. a DAC-write client and a sensor-read client.
- Picks a winner round-robin and latches its address, direction and write byte.
- Issues a single-cycle Go to the controller, then waits for Done with a watchdog timeout.
- Returns completion status and any read data to the winner.
- Sits between the client logic and the I2C control unit/datapath in the top level.

Parameters:
- TIMEOUT_CYCLES, 4096: clock cycles allowed in WAIT before the transaction is aborted.
- TW, 12: timer width; must satisfy 2^TW >= TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  2  request per client; bit i is client i.
- Addr0, Addr1  in  7 each  7-bit slave address per client.
- RW0, RW1  in  1 each  direction per client; 1 = read, 0 = write.
- WData0, WData1  in  8 each  write byte per client.
- Grant  out  2  one-hot owner of the bus; 0 when idle.
- RspDone  out  2  one-cycle completion pulse to the owning client.
- RspOK  out  1  slave acknowledged; valid while RspDone is nonzero.
- RspTimeout  out  1  transaction aborted by the watchdog; valid while RspDone is nonzero.
- RspData  out  8  read byte; valid while RspDone is nonzero.
- Go  out  1  one-cycle start strobe to the controller.
- CtlAddr  out  7  latched address for the controller.
- CtlRW  out  1  latched direction for the controller.
- CtlWData  out  8  latched write byte for the controller.
- CtlDone  in  1  one-cycle pulse from the controller at the end of a transaction.
- CtlAckOK  in  1  slave ACK status; valid with CtlDone.
- CtlRdData  in  8  read byte; valid with CtlDone.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transaction):
  - State = IDLE.
  - All outputs = 0.
  - Timer = 0.
  - LastGnt = 1, so client 0 wins the first tie.
- State IDLE:
  - Grant = 0.
  - Req = 00: stay in IDLE.
  - Exactly one Req bit set: that client wins.
  - Req = 11: the client other than LastGnt wins.
  - On a win: go to LATCH. On that same edge, load Grant (one-hot winner), CtlAddr, CtlRW and CtlWData from the winner's inputs.
- State LATCH:
  - Stays one cycle, then goes to LAUNCH.
  - Go = 1 in the LAUNCH cycle only.
- State LAUNCH:
  - Stays one cycle; timer cleared to 0; then goes to WAIT.
- State WAIT:
  - Timer increments by 1 each cycle.
  - CtlDone = 1: go to COMPLETE; capture RspOK = CtlAckOK and RspData = CtlRdData; RspTimeout = 0.
  - Else, if timer = TIMEOUT_CYCLES-1: go to COMPLETE; RspOK = 0, RspTimeout = 1, RspData = 0.
  - CtlDone and timeout in the same cycle: Done wins.
- State COMPLETE:
  - Stays one cycle.
  - RspDone = Grant, i.e. a pulse on the owner's bit.
  - LastGnt is updated to the owner.
  - Next state is IDLE; Grant, RspDone and the Rsp fields clear on entering IDLE.
  - CtlAddr, CtlRW and CtlWData hold their last values.
- Latency, with Req seen in IDLE at edge n:
  - Grant visible at n+1.
  - Go at n+2.
  - With CtlDone sampled at edge m, RspDone is visible at m+1.
- CtlDone outside WAIT is ignored.
- Req or client inputs changing after LATCH are ignored; the latched values are used.
- Dropping Req mid-transaction does not abort.
- Req still high in IDLE after completion is a new request:
  - With the other client requesting, the other client wins.
  - Alone, it is re-granted. Back-to-back service costs 1 IDLE cycle between COMPLETE and the next LATCH.
- A tie is decided only by LastGnt; there is no starvation. With both clients requesting continuously, grants strictly alternate.

Test Plan:
- Reset, then Req=01, Addr0=0x48, RW0=0, WData0=0xA5 -> Grant=01 at n+1; CtlAddr=0x48, CtlRW=0, CtlWData=0xA5; Go high exactly one cycle at n+2. CtlDone with AckOK=1 -> RspDone=01, RspOK=1, RspTimeout=0, then Grant=00.
- Req=11 held for 4 transactions, each CtlDone given 5 cycles after Go -> grant order 01,10,01,10; CtlAddr tracks the owner each time.
- Req=10, RW1=1, CtlDone with CtlRdData=0x3C and AckOK=0 -> RspDone=10, RspData=0x3C, RspOK=0.
- TIMEOUT_CYCLES=16, no CtlDone -> RspDone pulse exactly 16 cycles after WAIT entry; RspTimeout=1, RspOK=0. Repeat with CtlDone on the final cycle -> RspTimeout=0.
- Client 0 changes Addr0 and drops Req during WAIT -> CtlAddr unchanged; the transaction still completes with a RspDone=01 pulse.
- Reset asserted mid-WAIT, then released -> all outputs 0 immediately. A new Req=11 -> Grant=01 (LastGnt reset to 1). A stray CtlDone in IDLE produces no RspDone.
